// File: rtl/cpu_pkg.sv
// Shared constants and helpers for the 32-bit single-cycle CPU datapath.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int REG_W  = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  // I-type view of an instruction word; rd lives in imm[15:11].
  typedef struct packed {
    logic [5:0]       op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [15:0]      imm;
  } instr_t;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction
endpackage

// File: rtl/idecode32_regfile.sv
// 32x32 register file: two async read ports, one sync write port, $0 hardwired.
module idecode32_regfile
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_W-1:0]  raddr1,
  input  logic [REG_W-1:0]  raddr2,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != REG_ZERO)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // No bypass: a register written this cycle still reads its old value.
  assign rdata1 = (raddr1 == REG_ZERO) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == REG_ZERO) ? '0 : regs_q[raddr2];
endmodule

// File: rtl/idecode32.sv
// Instruction-decode stage: register reads, immediate extension, write-back muxing.
module idecode32
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] Instruction,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic              Jal,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              RegDst,
  input  logic [DATA_W-1:0] opcplus4,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] Sign_extend
);
  instr_t            ins;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] imm_ext;

  assign ins = instr_t'(Instruction);
  assign rd  = ins.imm[15:11];

  always_comb begin
    imm_ext = {{16{ins.imm[15]}}, ins.imm};
    if (is_zext(ins.op)) imm_ext = {16'h0000, ins.imm};
  end

  // Jal overrides both destination and source selection.
  always_comb begin
    waddr = ins.rt;
    wdata = ALU_result;
    if (Jal) begin
      waddr = REG_RA;
      wdata = opcplus4;
    end else begin
      if (RegDst)   waddr = rd;
      if (MemtoReg) wdata = read_data;
    end
  end

  assign Sign_extend = imm_ext;

  idecode32_regfile u_regfile (
    .clock  (clock),
    .reset  (reset),
    .raddr1 (ins.rs),
    .raddr2 (ins.rt),
    .we     (RegWrite),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata1 (read_data_1),
    .rdata2 (read_data_2)
  );
endmodule

// File: tb/tb_idecode32.sv
// Directed self-checking bench for idecode32.
module tb_idecode32;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Instruction, read_data, ALU_result, opcplus4;
  logic        Jal, RegWrite, MemtoReg, RegDst;
  logic [31:0] read_data_1, read_data_2, Sign_extend;

  int checks = 0;
  int errors = 0;

  idecode32 dut (
    .clock       (clock),
    .reset       (reset),
    .Instruction (Instruction),
    .read_data   (read_data),
    .ALU_result  (ALU_result),
    .Jal         (Jal),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .opcplus4    (opcplus4),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .Sign_extend (Sign_extend)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Read register r through both ports.
  task automatic rd_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    Instruction = {6'b000000, r, r, 16'h0000};
    #1;
    chk({tag, ".rs"}, read_data_1, exp);
    chk({tag, ".rt"}, read_data_2, exp);
  endtask

  task automatic ctl(input logic jal, input logic rw, input logic m2r, input logic dst);
    Jal = jal; RegWrite = rw; MemtoReg = m2r; RegDst = dst;
  endtask

  initial begin
    reset = 1'b0; Instruction = '0; read_data = '0; ALU_result = '0; opcplus4 = '0;
    ctl(0, 0, 0, 0);
    @(negedge clock);
    step(); step();
    reset = 1'b1;

    for (int r = 0; r < 32; r++) begin
      Instruction = {6'b000000, 5'(r), 5'(31 - r), 16'h0000};
      #1;
      chk($sformatf("rst_rs%0d", r), read_data_1, 32'h0);
      chk($sformatf("rst_rt%0d", r), read_data_2, 32'h0);
    end

    // add $7,$2,$3
    Instruction = 32'h00433820; ctl(0, 1, 0, 1); ALU_result = 32'h5;
    step();
    // addi $3,$7,0x8037
    Instruction = 32'h20E38037; ctl(0, 1, 0, 0); ALU_result = 32'hFFFF803C;
    #1;
    chk("addi_rs", read_data_1, 32'h5);
    chk("addi_rt_old", read_data_2, 32'h0);
    chk("addi_sext", Sign_extend, 32'hFFFF8037);
    step();
    rd_reg("reg3", 5'd3, 32'hFFFF803C);

    // addi $3,$3,... : same-cycle read sees old value
    Instruction = 32'h20630011; ctl(0, 1, 0, 0); ALU_result = 32'h11;
    #1;
    chk("same_cyc_old", read_data_1, 32'hFFFF803C);
    step();
    rd_reg("reg3_new", 5'd3, 32'h11);

    // andi $4,$2,0x8097
    Instruction = 32'h30448097; ctl(0, 1, 0, 0); ALU_result = 32'h2;
    #1;
    chk("andi_zext", Sign_extend, 32'h00008097);
    step();
    rd_reg("reg4", 5'd4, 32'h2);
    ctl(0, 0, 0, 0);
    Instruction = 32'h34458001; #1; chk("ori_zext", Sign_extend, 32'h00008001);
    Instruction = 32'h38458001; #1; chk("xori_zext", Sign_extend, 32'h00008001);
    Instruction = 32'h20E30001; #1; chk("addi_pos", Sign_extend, 32'h00000001);

    // lw $6,0x100($0)
    Instruction = 32'h8C060100; ctl(0, 1, 1, 0); read_data = 32'h7B; ALU_result = 32'h54;
    #1;
    chk("lw_sext", Sign_extend, 32'h00000100);
    step();
    rd_reg("reg6", 5'd6, 32'h7B);

    // jal
    Instruction = 32'h0C000000; ctl(1, 1, 0, 0); opcplus4 = 32'h18; ALU_result = 32'h4;
    step();
    rd_reg("reg31", 5'd31, 32'h18);
    rd_reg("reg0_jal", 5'd0, 32'h0);

    // Jal priority over RegDst/MemtoReg; rd field = 5
    Instruction = 32'h0C002800; ctl(1, 1, 1, 1); opcplus4 = 32'h20; read_data = 32'h99;
    step();
    rd_reg("jal_pri31", 5'd31, 32'h20);
    rd_reg("jal_pri5", 5'd5, 32'h0);

    // write to $0 discarded
    Instruction = 32'h00000000; ctl(0, 1, 0, 1); ALU_result = 32'hDEAD;
    step();
    rd_reg("reg0", 5'd0, 32'h0);

    // RegWrite=0: rd=7 unchanged
    Instruction = 32'h00003800; ctl(0, 0, 0, 1); ALU_result = 32'h1234;
    step();
    rd_reg("nowr7", 5'd7, 32'h5);

    // reset coincident with write to $8
    Instruction = 32'h20084321; ctl(0, 1, 0, 0); ALU_result = 32'hAB; reset = 1'b0;
    #1;
    chk("rst_sext", Sign_extend, 32'h00004321);
    step();
    rd_reg("rst_reg8", 5'd8, 32'h0);
    rd_reg("rst_reg7", 5'd7, 32'h0);
    rd_reg("rst_reg31", 5'd31, 32'h0);
    reset = 1'b1; ctl(0, 0, 0, 0);
    step();
    rd_reg("post_rst8", 5'd8, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/idecode32.md
Name: idecode32

Overview:
- Instruction-decode stage of the single-cycle 32-bit MIPS (Minisys-style) CPU.
- Holds the 32x32 general register file and reads rs/rt combinationally.
- Produces the 32-bit extended immediate.
- Performs register write-back from ALU, memory/IO or JAL link address, selected by controller signals.

Parameters:
- None. The datapath is fixed at 32 bits with 32 registers.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising clock edge; 0 clears the register file.
- Instruction  in  32  current instruction word.
- read_data  in  32  load data from data RAM / IO.
- ALU_result  in  32  ALU output for write-back.
- Jal  in  1  current instruction is JAL.
- RegWrite  in  1  register-file write enable.
- MemtoReg  in  1  write-back source is read_data (1) or ALU_result (0).
- RegDst  in  1  destination is rd (1) or rt (0).
- opcplus4  in  32  PC+4 byte address from the fetch unit; used as JAL link value.
- read_data_1  out  32  contents of register rs.
- read_data_2  out  32  contents of register rt.
- Sign_extend  out  32  extended 16-bit immediate.

Behaviour:
- Field decode:
  - opcode = Instruction[31:26]
  - rs = [25:21]
  - rt = [20:16]
  - rd = [15:11]
  - imm = [15:0]
- Reads are combinational, with zero latency: read_data_1 = reg[rs], read_data_2 = reg[rt].
- Register 0 always reads 0.
- Immediate extension (combinational):
  - opcode 001100 (andi), 001101 (ori), 001110 (xori): zero-extend, {16'h0, imm}.
  - All other opcodes: sign-extend, {{16{imm[15]}}, imm}.
- Write address:
  - Jal=1 → 31.
  - else RegDst=1 → rd.
  - else rt.
- Write data:
  - Jal=1 → opcplus4.
  - else MemtoReg=1 → read_data.
  - else ALU_result.
- Jal has priority over RegDst and MemtoReg.
- Write timing:
  - On rising clock edge, if reset=1 and RegWrite=1 and write address ≠ 0, reg[waddr] ← wdata.
  - The write is visible on the read ports after that edge (one-cycle write latency).
- Writes to register 0 are discarded.
- Same-cycle read of the register being written returns the old value; there is no write-through bypass.
- Reset:
  - On rising edge with reset=0, all 32 registers clear to 0. Reset overrides RegWrite.
  - Reset asserted mid-program discards any pending write in that cycle.
  - Outputs during reset follow the combinational rules applied to the cleared file: read_data_1/2 = 0, Sign_extend still decodes Instruction.
- No X propagation: a zero-initialised register file is required in simulation as well.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants: OP_RTYPE 000000, OP_ADDI 001000, OP_ANDI 001100, OP_ORI 001101, OP_XORI 001110, OP_LW 100011, OP_JAL 000011.
  - register index constants REG_ZERO=0, REG_RA=31.
  - DATA_W=32.
- One natural sub-module: idecode32_regfile, holding the 32x32 storage, two asynchronous read ports, one synchronous write port, $0 hardwiring and reset clear.
- Top level keeps the mux and extension logic.

Test Plan:
1. Reset held low for 2 edges, then released → read_data_1/2 = 0 for every rs/rt.
2. add $7,$2,$3 (0x00433820), RegDst=1, RegWrite=1, ALU_result=5 → after edge reg7=5. Then addi $3,$7,0x8037 (0x20E38037) → read_data_1=5, Sign_extend=0xFFFF8037; with RegDst=0, ALU_result=0xFFFF803C → reg3=0xFFFF803C.
3. andi $4,$2,0x8097 (0x30448097) → Sign_extend=0x00008097 (zero-extended). ALU_result=2 → reg4=2. Also check ori/xori zero-extend.
4. lw $6 (0x8C060100), MemtoReg=1, read_data=0x7B, ALU_result=0x54 → reg6=0x7B; Sign_extend=0x00000100.
5. JAL (0x0C000000), Jal=1, RegDst=0, opcplus4=0x18, ALU_result=4 → reg31=0x18 (not 4, not rt=0).
6. Edge cases:
   - Write to $0 with RegWrite=1 → $0 stays 0.
   - RegWrite=0 → no register changes.
   - reset=0 coincident with a write → write discarded, all registers 0.
   - Same-cycle read of written register shows the old value.
